// File: rtl/status_seq_monitor.sv
// status_seq_monitor: watches a registered status bus and checks that a list
// of checkpoint codes appears in order. Each code must stay stable for
// STABLE_CYCLES samples, and the whole sequence must finish within
// TIMEOUT_CYCLES of start.
// Optional feature macro: STATUS_SEQ_MONITOR_ORDER_CHECK_EN. When it is defined,
// a stable code that belongs to a later step ends the run in FAIL.
module status_seq_monitor #(
   parameter int          STATUS_W       = 4,
   parameter int          NUM_STEPS      = 3,
   parameter int          STABLE_CYCLES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 200000,
   localparam int         IDX_W          = $clog2(NUM_STEPS + 1)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic [STATUS_W-1:0]           status,
   input  logic [NUM_STEPS*STATUS_W-1:0] expect_codes,
   output logic                          busy,
   output logic [IDX_W-1:0]              step_idx,
   output logic                          step_pulse,
   output logic                          pass,
   output logic                          fail,
   output logic                          timeout,
   output logic [31:0]                   cycle_count
);

   localparam logic [7:0]  STAB_MAX = 8'(STABLE_CYCLES);
   localparam logic [31:0] TO_VAL   = 32'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_PASS, S_FAIL, S_TIMEOUT
   } state_t;

   state_t              state_q, state_d;
   logic [STATUS_W-1:0] samp;
   logic [7:0]          stab_cnt;
   logic                consumed;   // current stable period already used
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [31:0]         cc_q, cc_d;
   logic                pulse_q, pulse_d;
   logic [STATUS_W-1:0] cur_code;
   logic                stable;
   logic                accept;
   logic                order_err;
   logic                go;

   assign stable = (stab_cnt == STAB_MAX) && !consumed;
   assign accept = (state_q == S_WAIT) && stable && (samp == cur_code);
   assign go     = start && (state_q != S_WAIT);

   // select the code expected for the current step
   always_comb begin
      cur_code = '0;
      for (int i = 0; i < NUM_STEPS; i++)
         if (int'(idx_q) == i) cur_code = expect_codes[i*STATUS_W +: STATUS_W];
   end

`ifdef STATUS_SEQ_MONITOR_ORDER_CHECK_EN
   logic later_hit;

   // flag a stable sample that matches any code of a step not yet reached
   always_comb begin
      later_hit = 1'b0;
      for (int j = 0; j < NUM_STEPS; j++)
         if (j > int'(idx_q) && samp == expect_codes[j*STATUS_W +: STATUS_W])
            later_hit = 1'b1;
   end

   assign order_err = (state_q == S_WAIT) && stable && later_hit && (samp != cur_code);
`else
   assign order_err = 1'b0;
`endif

   // input sample register plus the stability run-length counter
   always_ff @(posedge clock) begin
      if (reset) begin
         samp     <= '0;
         stab_cnt <= '0;
         consumed <= 1'b0;
      end else begin
         samp <= status;
         if (status != samp) begin
            stab_cnt <= 8'd1;
            consumed <= 1'b0;
         end else begin
            if (stab_cnt < STAB_MAX) stab_cnt <= stab_cnt + 8'd1;
            if (accept)  consumed <= 1'b1;
            else if (go) consumed <= 1'b0;
         end
      end
   end

   // next-state logic; PASS beats FAIL, and FAIL beats TIMEOUT
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cc_d    = cc_q;
      pulse_d = 1'b0;
      case (state_q)
         S_WAIT: begin
            cc_d = cc_q + 32'd1;
            if (accept) begin
               idx_d   = idx_q + IDX_W'(1);
               pulse_d = 1'b1;
               if (int'(idx_q) == NUM_STEPS - 1) state_d = S_PASS;
            end else if (order_err) begin
               state_d = S_FAIL;
            end
            if (state_d == S_WAIT && cc_d >= TO_VAL) state_d = S_TIMEOUT;
         end
         default: begin
            if (start) begin
               state_d = S_WAIT;
               idx_d   = '0;
               cc_d    = '0;
            end
         end
      endcase
   end

   // state and run-progress registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cc_q    <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cc_q    <= cc_d;
         pulse_q <= pulse_d;
      end
   end

   assign busy        = (state_q == S_WAIT);
   assign pass        = (state_q == S_PASS);
   assign timeout     = (state_q == S_TIMEOUT);
   assign step_idx    = idx_q;
   assign step_pulse  = pulse_q;
   assign cycle_count = cc_q;
`ifdef STATUS_SEQ_MONITOR_ORDER_CHECK_EN
   assign fail        = (state_q == S_FAIL);
`else
   assign fail        = 1'b0;
`endif

endmodule

// File: tb/tb_status_seq_monitor.sv
// Testbench for status_seq_monitor. Codes 5,A,C; stability 2; timeout 1000.
module tb_status_seq_monitor;
   localparam int STATUS_W  = 4;
   localparam int NUM_STEPS = 3;
   localparam int IDX_W     = $clog2(NUM_STEPS + 1);

   logic                          clock = 1'b0;
   logic                          reset;
   logic                          start;
   logic [STATUS_W-1:0]           status;
   logic [NUM_STEPS*STATUS_W-1:0] expect_codes;
   logic                          busy;
   logic [IDX_W-1:0]              step_idx;
   logic                          step_pulse;
   logic                          pass;
   logic                          fail;
   logic                          timeout;
   logic [31:0]                   cycle_count;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int exp_v;

   always #5 clock = ~clock;

   status_seq_monitor #(
      .STATUS_W(STATUS_W), .NUM_STEPS(NUM_STEPS),
      .STABLE_CYCLES(2), .TIMEOUT_CYCLES(1000)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .status(status),
      .expect_codes(expect_codes), .busy(busy), .step_idx(step_idx),
      .step_pulse(step_pulse), .pass(pass), .fail(fail), .timeout(timeout),
      .cycle_count(cycle_count)
   );

   // scoreboard: every step_pulse must match the next queued step_idx
   always @(negedge clock) begin
      if (step_pulse === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_pulse: unexpected step_pulse, step_idx=%0d, nothing queued", step_idx);
         end else begin
            exp_v = exp_q.pop_front();
            if (int'(step_idx) !== exp_v) begin
               errors++;
               $display("FAIL sb_step_idx: got %0d expected %0d", step_idx, exp_v);
            end
         end
      end
   end

   task automatic hold(input logic [3:0] v, input int n);
      status = v;
      repeat (n) @(negedge clock);
   endtask

   task automatic start_run();
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock); reset = 1'b1; start = 1'b0; status = '0;
      @(negedge clock); reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; status = '0;
      repeat (2) @(negedge clock);
      checks++;
      if ({busy, step_pulse, pass, fail, timeout} !== 5'b0 || step_idx !== '0 || cycle_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: flags=%b idx=%0d cc=%0d expected all 0",
                  {busy, step_pulse, pass, fail, timeout}, step_idx, cycle_count);
      end
      reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (busy !== 1'b0 || pass !== 1'b0 || cycle_count !== 32'd0) begin
         errors++;
         $display("FAIL idle_hold: busy=%b pass=%b cc=%0d expected 0 0 0", busy, pass, cycle_count);
      end
   endtask

   task automatic test_full_pass();
      hold(4'h0, 3);
      start_run();
      hold(4'h0, 10);
      exp_q.push_back(1); hold(4'h5, 10);
      exp_q.push_back(2); hold(4'hA, 10);
      exp_q.push_back(3); hold(4'hC, 10);
      checks++;
      if (pass !== 1'b1 || busy !== 1'b0 || timeout !== 1'b0 || fail !== 1'b0) begin
         errors++;
         $display("FAIL full_flags: pass=%b busy=%b timeout=%b fail=%b expected 1 0 0 0", pass, busy, timeout, fail);
      end
      checks++;
      if (step_idx !== 2'd3) begin
         errors++;
         $display("FAIL full_idx: got %0d expected 3", step_idx);
      end
      checks++;
      if (cycle_count !== 32'd33) begin
         errors++;
         $display("FAIL full_cc: got %0d expected 33", cycle_count);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL full_sb_left: %0d pulses missing expected 0", exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      hold(4'h0, 3);
      start_run();
      checks++;
      if (busy !== 1'b1 || pass !== 1'b0 || step_idx !== '0 || cycle_count !== 32'd0) begin
         errors++;
         $display("FAIL restart: busy=%b pass=%b idx=%0d cc=%0d expected 1 0 0 0", busy, pass, step_idx, cycle_count);
      end
      do_reset();
   endtask

   task automatic test_timeout();
      int n;
      hold(4'h0, 3);
      start_run();
      exp_q.push_back(1);
      status = 4'h5;
      n = 0;
      while (timeout !== 1'b1 && n < 1100) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (timeout !== 1'b1 || n != 1000) begin
         errors++;
         $display("FAIL timeout_time: timeout=%b after %0d cycles expected 1 after 1000", timeout, n);
      end
      checks++;
      if (cycle_count !== 32'd1000 || step_idx !== 2'd1 || pass !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_state: cc=%0d idx=%0d pass=%b busy=%b expected 1000 1 0 0",
                  cycle_count, step_idx, pass, busy);
      end
   endtask

   task automatic test_pass_wins();
      hold(4'h0, 3);
      start_run();
      exp_q.push_back(1); hold(4'h5, 10);
      exp_q.push_back(2); hold(4'hA, 987);
      exp_q.push_back(3); hold(4'hC, 5);
      checks++;
      if (pass !== 1'b1 || timeout !== 1'b0 || cycle_count !== 32'd1000 || step_idx !== 2'd3) begin
         errors++;
         $display("FAIL pass_wins: pass=%b timeout=%b cc=%0d idx=%0d expected 1 0 1000 3",
                  pass, timeout, cycle_count, step_idx);
      end
   endtask

   task automatic test_glitch();
      hold(4'h0, 3);
      start_run();
      exp_q.push_back(1); hold(4'h5, 10);
      hold(4'hA, 1);
      hold(4'h5, 10);
      checks++;
      if (step_idx !== 2'd1 || busy !== 1'b1 || fail !== 1'b0) begin
         errors++;
         $display("FAIL glitch: idx=%0d busy=%b fail=%b expected 1 1 0", step_idx, busy, fail);
      end
      start = 1'b1;
      @(negedge clock); start = 1'b0;
      hold(4'h5, 3);
      checks++;
      if (step_idx !== 2'd1 || busy !== 1'b1 || cycle_count !== 32'd25) begin
         errors++;
         $display("FAIL start_ignored: idx=%0d busy=%b cc=%0d expected 1 1 25", step_idx, busy, cycle_count);
      end
      do_reset();
   endtask

   task automatic test_repeat_code();
      expect_codes = {4'hC, 4'h5, 4'h5};
      hold(4'h0, 3);
      start_run();
      exp_q.push_back(1); hold(4'h5, 10);
      checks++;
      if (step_idx !== 2'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL repeat_once: idx=%0d busy=%b expected 1 1", step_idx, busy);
      end
      hold(4'h0, 3);
      exp_q.push_back(2); hold(4'h5, 10);
      exp_q.push_back(3); hold(4'hC, 10);
      checks++;
      if (step_idx !== 2'd3 || pass !== 1'b1) begin
         errors++;
         $display("FAIL repeat_pass: idx=%0d pass=%b expected 3 1", step_idx, pass);
      end
      expect_codes = {4'hC, 4'hA, 4'h5};
      do_reset();
   endtask

   task automatic test_order();
      hold(4'h0, 3);
      start_run();
      exp_q.push_back(1); hold(4'h5, 10);
      hold(4'hC, 10);
`ifdef STATUS_SEQ_MONITOR_ORDER_CHECK_EN
      checks++;
      if (fail !== 1'b1 || busy !== 1'b0 || step_idx !== 2'd1 || pass !== 1'b0) begin
         errors++;
         $display("FAIL order_fail: fail=%b busy=%b idx=%0d pass=%b expected 1 0 1 0", fail, busy, step_idx, pass);
      end
      hold(4'hA, 5);
      checks++;
      if (fail !== 1'b1 || step_idx !== 2'd1) begin
         errors++;
         $display("FAIL order_sticky: fail=%b idx=%0d expected 1 1", fail, step_idx);
      end
`else
      checks++;
      if (fail !== 1'b0 || busy !== 1'b1 || step_idx !== 2'd1) begin
         errors++;
         $display("FAIL order_ignored: fail=%b busy=%b idx=%0d expected 0 1 1", fail, busy, step_idx);
      end
      exp_q.push_back(2); hold(4'hA, 10);
      exp_q.push_back(3); hold(4'hC, 10);
      checks++;
      if (pass !== 1'b1 || fail !== 1'b0) begin
         errors++;
         $display("FAIL order_continue: pass=%b fail=%b expected 1 0", pass, fail);
      end
`endif
      do_reset();
   endtask

   task automatic test_reset_mid();
      hold(4'h0, 3);
      start_run();
      exp_q.push_back(1); hold(4'h5, 10);
      exp_q.push_back(2); hold(4'hA, 10);
      checks++;
      if (step_idx !== 2'd2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: idx=%0d busy=%b expected 2 1", step_idx, busy);
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if ({busy, step_pulse, pass, fail, timeout} !== 5'b0 || step_idx !== '0 || cycle_count !== 32'd0) begin
         errors++;
         $display("FAIL mid_reset: flags=%b idx=%0d cc=%0d expected all 0",
                  {busy, step_pulse, pass, fail, timeout}, step_idx, cycle_count);
      end
      reset = 1'b0;
      hold(4'h0, 3);
      start_run();
      hold(4'h0, 10);
      exp_q.push_back(1); hold(4'h5, 10);
      exp_q.push_back(2); hold(4'hA, 10);
      exp_q.push_back(3); hold(4'hC, 10);
      checks++;
      if (pass !== 1'b1 || step_idx !== 2'd3 || cycle_count !== 32'd33) begin
         errors++;
         $display("FAIL mid_rerun: pass=%b idx=%0d cc=%0d expected 1 3 33", pass, step_idx, cycle_count);
      end
   endtask

   // run all scenarios in order
   initial begin
      start = 1'b0;
      status = '0;
      reset = 1'b1;
      expect_codes = {4'hC, 4'hA, 4'h5};
      test_reset();
      test_full_pass();
      test_back_to_back();
      test_timeout();
      do_reset();
      test_pass_wins();
      do_reset();
      test_glitch();
      test_repeat_code();
      test_order();
      test_reset_mid();
      repeat (3) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d pulses missing expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // global guard against a hung run
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/status_seq_monitor.md
STATUS_SEQ_MONITOR -- requirements
Module: status_seq_monitor

Interface
REQ-001 Parameter STATUS_W, default 4: width of the observed status bus.
REQ-002 Parameter NUM_STEPS, default 3: number of ordered checkpoint codes.
REQ-003 Parameter STABLE_CYCLES, default 2: consecutive identical samples required to accept a code (range 1..255).
REQ-004 Parameter TIMEOUT_CYCLES, default 200000: cycles from start before timeout (range 1..2^32-1).
REQ-005 Port clock, input, 1: single clock; all logic on rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: single-cycle request to begin a monitoring run.
REQ-008 Port status, input, STATUS_W: observed status bus (e.g. a GPIO nibble).
REQ-009 Port expect_codes, input, NUM_STEPS*STATUS_W: code i at bits [i*STATUS_W +: STATUS_W], step 0 first.
REQ-010 Port busy, output, 1: high in WAIT state.
REQ-011 Port step_idx, output, clog2(NUM_STEPS+1): number of steps accepted so far.
REQ-012 Port step_pulse, output, 1: one-cycle strobe per accepted step.
REQ-013 Port pass / fail / timeout, output, 1 each: sticky terminal flags.
REQ-014 Port cycle_count, output, 32: cycles elapsed since start, frozen at termination.

Function
REQ-015 States SHALL be IDLE, WAIT, PASS, FAIL, TIMEOUT; encoding free.
REQ-016 status SHALL be registered once (samp) before any comparison; comparisons use samp only.
REQ-017 A stability counter SHALL count consecutive cycles samp is unchanged, saturating at STABLE_CYCLES, and reset to 1 when samp changes.
REQ-018 IDLE/PASS/FAIL/TIMEOUT + start=1 -> WAIT next cycle; step_idx, cycle_count, terminal flags cleared in that same transition.
REQ-019 start while in WAIT SHALL be ignored.
REQ-020 In WAIT, cycle_count SHALL increment by 1 every cycle.
REQ-021 In WAIT, step k accepted when samp == code[step_idx] and stability count reaches STABLE_CYCLES; step_idx increments and step_pulse asserts on the following cycle.
REQ-022 A code SHALL be accepted once per stable period; after acceptance samp must change before the next step can be accepted, even if code[k+1]==code[k].
REQ-023 Acceptance of step NUM_STEPS-1 SHALL move WAIT -> PASS and set pass in the same cycle as the final step_pulse.
REQ-024 cycle_count reaching TIMEOUT_CYCLES in WAIT SHALL move to TIMEOUT and set timeout.
REQ-025 Final-step acceptance and timeout in the same cycle: PASS wins.
REQ-026 busy SHALL drop in the cycle any terminal flag sets; exactly one terminal flag high at a time.
REQ-027 Terminal states SHALL hold until start or reset.

Reset
REQ-028 reset=1 SHALL force IDLE and zero busy, step_idx, step_pulse, pass, fail, timeout, cycle_count, samp and stability count on the next edge, including mid-run.
REQ-029 reset SHALL take priority over start in the same cycle.

Configuration
REQ-030 Macro STATUS_SEQ_MONITOR_ORDER_CHECK_EN defined: in WAIT, a stable samp equal to any code[j] with j > step_idx and not equal to code[step_idx] SHALL move to FAIL and set fail.
REQ-031 Macro undefined: out-of-order codes SHALL be ignored; FAIL state and fail output remain present but fail is constant 0.

Verification (STATUS_W=4, NUM_STEPS=3, codes 5,A,C, STABLE_CYCLES=2, TIMEOUT_CYCLES=1000)
REQ-032 start; status 0->5->A->C each held 10 cycles -> three step_pulses, step_idx 1,2,3, pass=1, busy=0, cycle_count frozen.
REQ-033 start; status held at 5 only -> step_idx=1, timeout=1 at cycle_count=1000, pass=0.
REQ-034 start; status 5, then A for 1 cycle, back to 5 -> A glitch rejected, step_idx stays 1.
REQ-035 ORDER_CHECK_EN defined: start; status 5 then C -> fail=1, step_idx=1; undefined: same stimulus -> no fail, run continues.
REQ-036 reset asserted mid-run at step_idx=2 -> all outputs 0 next cycle; new start with full sequence -> pass=1.
